// File: rtl/fpu_pkg.sv
// Shared types and helpers for the float-to-int arbiter slice.
// Widths are sized for the largest supported requester count (8).
package fpu_pkg;

  localparam int FTOI_LAT = 2;
  localparam int MAX_IDW  = 3;

  typedef struct packed {
    logic [MAX_IDW-1:0] id;
    logic [31:0]        data;
  } ftoi_res_t;

  // First set bit of valid, searching ptr, ptr+1, ... modulo n.
  function automatic logic [MAX_IDW-1:0] rr_pick(input logic [7:0] valid,
                                                 input logic [MAX_IDW-1:0] ptr,
                                                 input int n);
    logic [MAX_IDW-1:0] pick;
    logic               found;
    logic [2:0]         ix;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ix = 3'((int'(ptr) + k) % n);
      if (k < n && !found && valid[ix]) begin
        pick  = MAX_IDW'(ix);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ftoi_arbiter_if.sv
// Request/response bundle between requesters and the shared converter arbiter.
// master drives requests and response ready; slave is the arbiter side.
interface ftoi_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_data;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_data;
  logic [IDW-1:0]     resp_id;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/ftoi.sv
// Two-stage float-to-int converter, round-half-up on magnitude; 2-cycle latency.
// Non-stallable: a new operand enters every cycle; out-of-range values are not flagged.
module ftoi (
  input  logic        clk,
  input  logic [31:0] x,
  output logic [31:0] y
);
  logic [7:0]  e;
  logic [23:0] m;
  logic [4:0]  rs;
  logic [31:0] mag_d;
  logic [31:0] mag_q;
  logic        sign_q;

  always_comb begin
    e     = x[30:23];
    m     = {1'b1, x[22:0]};
    rs    = '0;
    mag_d = '0;
    if (e == 8'd126) begin
      mag_d = 32'd1;
    end else if (e >= 8'd127 && e < 8'd150) begin
      // Fractional bits remain: shift them out and add the first dropped bit.
      rs    = 5'(8'd150 - e);
      mag_d = 32'(m >> rs) + {31'b0, m[rs - 5'd1]};
    end else if (e >= 8'd150) begin
      mag_d = 32'(m) << (e - 8'd150);
    end
  end

  always_ff @(posedge clk) begin
    sign_q <= x[31];
    mag_q  <= mag_d;
    y      <= sign_q ? (32'd0 - mag_q) : mag_q;
  end
endmodule

// File: rtl/ftoi_arbiter_res_fifo.sv
// Result FIFO: registered storage read first-word fall-through, separate occupancy counter.
// Push is never refused (upstream credit guarantees room); pop only takes effect when non-empty.
module ftoi_res_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  ftoi_res_t     push_dat,
  input  logic          pop,
  output ftoi_res_t     head,
  output logic          head_vld,
  output logic [CW-1:0] count
);
  ftoi_res_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_prev;
  logic          do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop   = pop && (count != '0);
  assign head_vld = (count != '0);
  assign rd_prev  = (rd_ptr == '0) ? PW'(DEPTH - 1) : rd_ptr - PW'(1);
  // When empty, the slot behind rd_ptr still holds the last popped entry.
  assign head     = head_vld ? mem[rd_ptr] : mem[rd_prev];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      if (push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end
endmodule

// File: rtl/ftoi_arbiter.sv
// Round-robin share of one 2-stage ftoi among NREQ requesters; accept to resp_valid is 3 cycles.
// Issue is credit-limited by FIFO occupancy plus in-flight ops; responses drain via resp_valid/resp_ready.
module ftoi_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic           clk,
  input  logic           rst,
  ftoi_arbiter_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IDW-1:0] rr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] id1;
  logic [IDW-1:0] id2;
  logic           v1;
  logic           v2;
  logic           any_valid;
  logic           can_issue;
  logic           accept;
  logic [CW-1:0]  count;
  logic [CW:0]    used;
  logic [31:0]    x;
  logic [31:0]    y;
  ftoi_res_t      push_dat;
  ftoi_res_t      head;
  logic           head_vld;

  always_comb begin
    grant     = IDW'(rr_pick(8'(bus.req_valid), MAX_IDW'(rr), NREQ));
    any_valid = |bus.req_valid;
    // A pop in this same cycle is deliberately not credited.
    used      = {1'b0, count} + {{CW{1'b0}}, v1} + {{CW{1'b0}}, v2};
    can_issue = int'(used) < DEPTH;
    accept    = can_issue && any_valid && !rst;
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant] = 1'b1;
    end
    x = accept ? bus.req_data[{grant, 5'b0} +: 32] : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr  <= '0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      id1 <= '0;
      id2 <= '0;
    end else begin
      v1  <= accept;
      v2  <= v1;
      id2 <= id1;
      if (accept) begin
        id1 <= grant;
        rr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
      end
    end
  end

  ftoi u_ftoi (
    .clk (clk),
    .x   (x),
    .y   (y)
  );

  always_comb begin
    push_dat      = '0;
    push_dat.id   = MAX_IDW'(id2);
    push_dat.data = y;
  end

  ftoi_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (v2),
    .push_dat (push_dat),
    .pop      (bus.resp_ready),
    .head     (head),
    .head_vld (head_vld),
    .count    (count)
  );

  assign bus.resp_valid = head_vld;
  assign bus.resp_data  = head.data;
  assign bus.resp_id    = head.id[IDW-1:0];
endmodule
